pe_dot_acc: RTL and testbench
=============================

// Module: pe_dot_acc
// PURPOSE
//  Streaming dot-product PE: accepts cfg_len operand pairs over a valid/ready stream,
//  multiplies each pair and accumulates, then presents one result with out_valid/out_ready.
//  INT_MODE selects signed-integer or bfloat-style FP datapath. Successor to single-op mul/add
//  units; sits between array operand buffers and the output collector.
// PARAMETERS
//  INT_MODE   0   0: FP (sign/EXP_BIT/MAT_BIT); 1: signed integer
//  EXP_BIT    8   FP exponent width (bias 2^(EXP_BIT-1)-1)
//  MAT_BIT    7   FP mantissa width (hidden 1 implied)
//  DATA_BIT   EXP_BIT+MAT_BIT+1  operand width (both modes)
//  ACC_BIT    32  INT accumulator/result width (>= 2*DATA_BIT)
//  CNT_BIT    8   width of cfg_len and beat counter
//  OUT_BIT    INT_MODE ? ACC_BIT : DATA_BIT  (localparam) result width
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         async active-low reset
//  start      in   1         begin a dot product; sampled only in IDLE
//  cfg_len    in   CNT_BIT   number of pairs, latched on accepted start
//  in_valid   in   1         operand pair valid
//  in_ready   out  1         PE accepts pair
//  idataA     in   DATA_BIT  operand A
//  idataB     in   DATA_BIT  operand B
//  out_valid  out  1         result valid, held until out_ready
//  out_ready  in   1         consumer accepts result
//  odata      out  OUT_BIT   dot-product result
//  busy       out  1         state != IDLE
//  ovf        out  1         sticky overflow flag for current result
// BEHAVIOUR
//  Reset (rst_n=0, async, any state): state=IDLE; in_ready, out_valid, busy, ovf, odata,
//   accumulator, product stage, counter all 0. Reset mid-operation discards the job.
//  FSM IDLE->ACC on start (cfg_len!=0); IDLE->OUT on start with cfg_len==0 (odata=0).
//   ACC->DRAIN after cfg_len-th beat; DRAIN->OUT after 2 cycles; OUT->IDLE when out_ready.
//  Beat = in_valid&&in_ready. in_ready=1 only in ACC while cnt<cfg_len; 0 elsewhere.
//  start while busy ignored. Accumulator cleared on accepted start.
//  Pipeline: edge N beat -> product reg (S1); edge N+1 acc+=S1; last beat at edge N ->
//   out_valid=1, odata=acc after edge N+2. Gaps in in_valid allowed; throughput 1 pair/cycle.
//  out_valid/odata stable while out_ready=0; out_valid drops edge after out_ready=1.
//  INT: product = signed DATA_BIT x DATA_BIT -> 2*DATA_BIT, sign-extended to ACC_BIT; add wraps
//   mod 2^ACC_BIT unless PE_DOT_SAT_EN.
//  FP: operand exp==0 -> zero (no denormals); product exp<bias -> 0; mantissa truncated (no
//   rounding); add aligns smaller operand, sub/add, lead-one normalise, truncate; exact
//   cancellation -> all-zero; underflow -> 0; exponent overflow -> max finite (exp=all1-1,
//   mat=all1, sign kept) and ovf=1. No Inf/NaN handling.
//  ovf cleared on accepted start.
// CONFIGURATION
//  PE_DOT_SAT_EN defined: INT accumulator saturates to +/-2^(ACC_BIT-1) bounds on overflow,
//   ovf=1. Undefined: INT wraps; ovf still set on signed overflow. FP unaffected.
// TESTING
//  INT_MODE=1,DATA_BIT=8,ACC_BIT=32, len=4, A={1,-2,3,127} B={2,3,-4,127} -> odata=16113.
//  FP bf16, len=2, A={0x3F80,0x3FC0} B={0x4000,0x4000} -> odata=0x40A0 (5.0), ovf=0.
//  start with cfg_len=0 -> no in_ready, out_valid after 1 cycle, odata=0.
//  INT ACC_BIT=16, 4x(127*127): with PE_DOT_SAT_EN odata=0x7FFF ovf=1; without 0xFC04 ovf=1.
//  Hold out_ready=0 5 cycles, toggle in_valid mid-job -> odata stable, in_ready=0, no loss.
//  FP A={0x4000,0xC000} B={0x3F80,0x3F80} -> 0x0000; rst_n low mid-ACC -> all outputs 0, IDLE.

Source files
------------

// File: rtl/pe_dot_acc.sv
`default_nettype none
//==============================================================================
// Module   : pe_dot_acc
// Brief    : Streaming dot-product PE (signed-int or bfloat-style FP datapath).
//            Build option PE_DOT_SAT_EN: saturating INT accumulator.
// Revision : 1.0  initial release
//==============================================================================
module pe_dot_acc #(
    parameter int INT_MODE = 0,
    parameter int EXP_BIT  = 8,
    parameter int MAT_BIT  = 7,
    parameter int DATA_BIT = EXP_BIT + MAT_BIT + 1,
    parameter int ACC_BIT  = 32,
    parameter int CNT_BIT  = 8,
    localparam int OUT_BIT = (INT_MODE != 0) ? ACC_BIT : DATA_BIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_BIT-1:0]  cfg_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_BIT-1:0] idataA,
    input  logic [DATA_BIT-1:0] idataB,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BIT-1:0]  odata,
    output logic                busy,
    output logic                ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_BIT-1:0]   r_cnt;
    logic [CNT_BIT-1:0]   r_len;
    logic                 r_drain;
    logic                 r_p_valid;
    logic                 r_ovf;
    logic [OUT_BIT-1:0]   r_odata;

    logic                 w_start_acc;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_ovf_evt;
    logic [OUT_BIT-1:0]   w_acc_value;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign in_ready    = (r_state == S_ACC) && (r_cnt < r_len);
    assign w_beat      = in_valid && in_ready;
    assign w_last      = w_beat && (r_cnt == r_len - CNT_BIT'(1));
    assign out_valid   = (r_state == S_OUT);
    assign busy        = (r_state != S_IDLE);
    assign ovf         = r_ovf;
    assign odata       = r_odata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_state_nxt = (cfg_len == '0) ? S_OUT : S_ACC;
            S_ACC:   if (w_last)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_drain)   w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN lasts two cycles: one for the last product, one for its accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_len     <= '0;
            r_drain   <= 1'b0;
            r_p_valid <= 1'b0;
            r_ovf     <= 1'b0;
            r_odata   <= '0;
        end else begin
            r_p_valid <= w_beat;
            r_drain   <= (r_state == S_DRAIN) && !r_drain;
            if (w_start_acc) begin
                r_cnt <= '0;
                r_len <= cfg_len;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_BIT'(1);
            end
            if (w_start_acc) begin
                r_ovf <= 1'b0;
            end else if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end
            if (w_start_acc && (cfg_len == '0)) begin
                r_odata <= '0;
            end else if ((r_state == S_DRAIN) && r_drain) begin
                r_odata <= w_acc_value;
            end
        end
    end

    generate
        if (INT_MODE != 0) begin : g_int
            logic signed [2*DATA_BIT-1:0] w_a_ext;
            logic signed [2*DATA_BIT-1:0] w_b_ext;
            logic signed [2*DATA_BIT-1:0] w_mul;
            logic        [ACC_BIT-1:0]    w_prod_ext;
            logic        [ACC_BIT-1:0]    w_sum;
            logic        [ACC_BIT-1:0]    w_next;
            logic                         w_of;
            logic        [ACC_BIT-1:0]    r_prod;
            logic        [ACC_BIT-1:0]    r_acc;

            assign w_a_ext    = (2*DATA_BIT)'($signed(idataA));
            assign w_b_ext    = (2*DATA_BIT)'($signed(idataB));
            assign w_mul      = w_a_ext * w_b_ext;
            assign w_prod_ext = ACC_BIT'(w_mul);
            assign w_sum      = r_acc + r_prod;
            // Signed overflow: operands agree in sign, result does not.
            assign w_of       = (r_acc[ACC_BIT-1] == r_prod[ACC_BIT-1]) &&
                                (w_sum[ACC_BIT-1] != r_acc[ACC_BIT-1]);
`ifdef PE_DOT_SAT_EN
            localparam logic [ACC_BIT-1:0] SAT_MAX = {1'b0, {(ACC_BIT-1){1'b1}}};
            localparam logic [ACC_BIT-1:0] SAT_MIN = {1'b1, {(ACC_BIT-1){1'b0}}};
            assign w_next = w_of ? (r_acc[ACC_BIT-1] ? SAT_MIN : SAT_MAX) : w_sum;
`else
            assign w_next = w_sum;
`endif
            assign w_ovf_evt   = r_p_valid && w_of;
            assign w_acc_value = r_acc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prod <= '0;
                    r_acc  <= '0;
                end else begin
                    if (w_beat) begin
                        r_prod <= w_prod_ext;
                    end
                    if (w_start_acc) begin
                        r_acc <= '0;
                    end else if (r_p_valid) begin
                        r_acc <= w_next;
                    end
                end
            end
        end else begin : g_fp
            localparam int                  BIAS    = (1 << (EXP_BIT - 1)) - 1;
            localparam logic [EXP_BIT-1:0]  EXP_MAX = {EXP_BIT{1'b1}};
            localparam logic [DATA_BIT-2:0] MAG_MAX = {EXP_MAX - EXP_BIT'(1), {MAT_BIT{1'b1}}};

            // Result packing for both helpers: {overflow, sign, exp, mantissa}.
            function automatic logic [DATA_BIT:0] fp_mul(input logic [DATA_BIT-1:0] a,
                                                         input logic [DATA_BIT-1:0] b);
                logic                   sign;
                logic [EXP_BIT-1:0]     ea;
                logic [EXP_BIT-1:0]     eb;
                logic [2*MAT_BIT+1:0]   mp;
                logic [MAT_BIT-1:0]     mant;
                int                     e;
                sign = a[DATA_BIT-1] ^ b[DATA_BIT-1];
                ea   = a[DATA_BIT-2:MAT_BIT];
                eb   = b[DATA_BIT-2:MAT_BIT];
                mp   = (2*MAT_BIT+2)'({1'b1, a[MAT_BIT-1:0]}) *
                       (2*MAT_BIT+2)'({1'b1, b[MAT_BIT-1:0]});
                e    = int'(ea) + int'(eb) - BIAS;
                if (mp[2*MAT_BIT+1]) begin
                    mant = MAT_BIT'(mp >> (MAT_BIT + 1));
                    e    = e + 1;
                end else begin
                    mant = MAT_BIT'(mp >> MAT_BIT);
                end
                if ((ea == '0) || (eb == '0) || (e <= 0)) begin
                    fp_mul = '0;
                end else if (e >= int'(EXP_MAX)) begin
                    fp_mul = {1'b1, sign, MAG_MAX};
                end else begin
                    fp_mul = {1'b0, sign, EXP_BIT'(e), mant};
                end
            endfunction

            function automatic logic [DATA_BIT:0] fp_add(input logic [DATA_BIT-1:0] x,
                                                         input logic [DATA_BIT-1:0] y);
                logic [DATA_BIT-1:0]    big;
                logic [DATA_BIT-1:0]    sml;
                logic [EXP_BIT-1:0]     e_big;
                logic [EXP_BIT-1:0]     e_sml;
                logic [MAT_BIT+1:0]     m_big;
                logic [MAT_BIT+1:0]     m_sml;
                logic [MAT_BIT+1:0]     s;
                logic [MAT_BIT-1:0]     mant;
                int                     e;
                int                     p;
                if (x[DATA_BIT-2:0] >= y[DATA_BIT-2:0]) begin
                    big = x;
                    sml = y;
                end else begin
                    big = y;
                    sml = x;
                end
                e_big  = big[DATA_BIT-2:MAT_BIT];
                e_sml  = sml[DATA_BIT-2:MAT_BIT];
                m_big  = {2'b01, big[MAT_BIT-1:0]};
                m_sml  = {2'b01, sml[MAT_BIT-1:0]} >> (e_big - e_sml);
                e      = int'(e_big);
                mant   = '0;
                p      = 0;
                fp_add = {1'b0, big};
                if (e_sml == '0) begin
                    fp_add = {1'b0, big};
                end else if (big[DATA_BIT-1] == sml[DATA_BIT-1]) begin
                    s = m_big + m_sml;
                    if (s[MAT_BIT+1]) begin
                        mant = s[MAT_BIT:1];
                        e    = e + 1;
                    end else begin
                        mant = s[MAT_BIT-1:0];
                    end
                    if (e >= int'(EXP_MAX)) begin
                        fp_add = {1'b1, big[DATA_BIT-1], MAG_MAX};
                    end else begin
                        fp_add = {1'b0, big[DATA_BIT-1], EXP_BIT'(e), mant};
                    end
                end else begin
                    s = m_big - m_sml;
                    if (s == '0) begin
                        fp_add = '0;
                    end else begin
                        for (int i = 0; i <= MAT_BIT; i++) begin
                            if (s[i]) p = i;
                        end
                        e = e - (MAT_BIT - p);
                        if (e <= 0) begin
                            fp_add = '0;
                        end else begin
                            mant   = MAT_BIT'(s << (MAT_BIT - p));
                            fp_add = {1'b0, big[DATA_BIT-1], EXP_BIT'(e), mant};
                        end
                    end
                end
            endfunction

            logic [DATA_BIT:0]   w_mul_r;
            logic [DATA_BIT:0]   w_add_r;
            logic [DATA_BIT-1:0] r_prod;
            logic [DATA_BIT-1:0] r_acc;

            assign w_mul_r     = fp_mul(idataA, idataB);
            assign w_add_r     = fp_add(r_acc, r_prod);
            assign w_ovf_evt   = (w_beat && w_mul_r[DATA_BIT]) || (r_p_valid && w_add_r[DATA_BIT]);
            assign w_acc_value = r_acc;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prod <= '0;
                    r_acc  <= '0;
                end else begin
                    if (w_beat) begin
                        r_prod <= w_mul_r[DATA_BIT-1:0];
                    end
                    if (w_start_acc) begin
                        r_acc <= '0;
                    end else if (r_p_valid) begin
                        r_acc <= w_add_r[DATA_BIT-1:0];
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pe_dot_acc.sv
`default_nettype none
//==============================================================================
// Module   : tb_pe_dot_acc
// Brief    : Directed self-checking bench for pe_dot_acc (INT32, INT16, bf16).
// Revision : 1.0  initial release
//==============================================================================
module tb_pe_dot_acc;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start_v;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] da;
    logic [15:0] db;
    logic [2:0]  rdy, ov, bz, of;
    logic [31:0] od_int;
    logic [15:0] od_i16;
    logic [15:0] od_fp;

    logic [15:0] va [8];
    logic [15:0] vb [8];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pe_dot_acc #(.INT_MODE(1), .EXP_BIT(4), .MAT_BIT(3), .DATA_BIT(8), .ACC_BIT(32), .CNT_BIT(8)) u_int (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(rdy[0]), .idataA(da[7:0]), .idataB(db[7:0]),
        .out_valid(ov[0]), .out_ready(out_ready), .odata(od_int), .busy(bz[0]), .ovf(of[0]));

    pe_dot_acc #(.INT_MODE(1), .EXP_BIT(4), .MAT_BIT(3), .DATA_BIT(8), .ACC_BIT(16), .CNT_BIT(8)) u_i16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(rdy[1]), .idataA(da[7:0]), .idataB(db[7:0]),
        .out_valid(ov[1]), .out_ready(out_ready), .odata(od_i16), .busy(bz[1]), .ovf(of[1]));

    pe_dot_acc #(.INT_MODE(0), .EXP_BIT(8), .MAT_BIT(7), .ACC_BIT(32), .CNT_BIT(8)) u_fp (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .cfg_len(cfg_len),
        .in_valid(in_valid), .in_ready(rdy[2]), .idataA(da), .idataB(db),
        .out_valid(ov[2]), .out_ready(out_ready), .odata(od_fp), .busy(bz[2]), .ovf(of[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] odata_of(input int sel);
        case (sel)
            0:       return od_int;
            1:       return {16'h0, od_i16};
            default: return {16'h0, od_fp};
        endcase
    endfunction

    task automatic set4(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
        vb[0] = b0; vb[1] = b1; vb[2] = b2; vb[3] = b3;
    endtask

    // One full job on instance sel; lat counts edges from last beat to out_valid.
    task automatic run_job(input int sel, input int len, input bit gap, input int hold,
                           output logic [31:0] res, output logic ovf_o, output int lat);
        int   i;
        int   cyc;
        logic r;
        logic stable;
        @(negedge clk);
        start_v[sel] = 1'b1;
        cfg_len      = 8'(len);
        @(negedge clk);
        start_v = '0;
        i   = 0;
        cyc = 0;
        while (i < len && cyc < 100) begin
            if (gap && (cyc % 2 == 1)) begin
                in_valid = 1'b0; da = 16'hFFFF; db = 16'hFFFF;
            end else begin
                in_valid = 1'b1; da = va[i]; db = vb[i];
            end
            r = rdy[sel];
            @(posedge clk);
            if (in_valid && r) i++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res    = odata_of(sel);
        ovf_o  = of[sel];
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = h[0];
            da = 16'h1234;
            db = 16'h4321;
            if (odata_of(sel) !== res || !ov[sel] || rdy[sel]) stable = 1'b0;
        end
        in_valid = 1'b0;
        if (hold > 0) check("hold_stable", {31'h0, stable}, 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_drop", {30'h0, ov[sel], bz[sel]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic        ovf_o;
        int          lat;
        logic [31:0] sat_exp;

        start_v = '0; cfg_len = '0; in_valid = 1'b0; out_ready = 1'b0; da = '0; db = '0;
        repeat (3) @(negedge clk);
        check("rst_flags", {20'h0, rdy, ov, bz, of}, 32'h0);
        check("rst_od_int", od_int, 32'h0);
        check("rst_od_fp", {od_i16, od_fp}, 32'h0);
        rst_n = 1'b1;

        set4(16'h01, 16'hFE, 16'h03, 16'h7F, 16'h02, 16'h03, 16'hFC, 16'h7F);
        run_job(0, 4, 1'b0, 0, res, ovf_o, lat);
        check("int_dot", res, 32'd16113);
        check("int_ovf", {31'h0, ovf_o}, 32'h0);
        check("int_lat", lat, 32'd2);

        set4(16'h05, 16'hF9, 16'h80, 16'h80, 16'hFD, 16'h09, 16'h80, 16'h7F);
        run_job(0, 4, 1'b1, 5, res, ovf_o, lat);
        check("int_gap_dot", res, 32'd50);
        check("int_gap_lat", lat, 32'd2);

        run_job(0, 0, 1'b0, 2, res, ovf_o, lat);
        check("zero_len_od", res, 32'h0);
        check("zero_len_lat", lat, 32'd0);

`ifdef PE_DOT_SAT_EN
        sat_exp = 32'h7FFF;
`else
        sat_exp = 32'hFC04;
`endif
        set4(16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h7F, 16'h7F);
        run_job(1, 4, 1'b0, 0, res, ovf_o, lat);
        check("i16_ovf_od", res, sat_exp);
        check("i16_ovf_flag", {31'h0, ovf_o}, 32'h1);

        set4(16'h01, 16'h00, 16'h00, 16'h00, 16'h01, 16'h00, 16'h00, 16'h00);
        run_job(1, 1, 1'b0, 0, res, ovf_o, lat);
        check("i16_small_od", res, 32'h1);
        check("i16_ovf_clr", {31'h0, ovf_o}, 32'h0);

        set4(16'h3F80, 16'h3FC0, 16'h0, 16'h0, 16'h4000, 16'h4000, 16'h0, 16'h0);
        run_job(2, 2, 1'b0, 0, res, ovf_o, lat);
        check("fp_dot", res, 32'h40A0);
        check("fp_ovf", {31'h0, ovf_o}, 32'h0);
        check("fp_lat", lat, 32'd2);

        set4(16'h4000, 16'hC000, 16'h0, 16'h0, 16'h3F80, 16'h3F80, 16'h0, 16'h0);
        run_job(2, 2, 1'b0, 0, res, ovf_o, lat);
        check("fp_cancel", res, 32'h0);

        set4(16'h7F00, 16'h0, 16'h0, 16'h0, 16'h7F00, 16'h0, 16'h0, 16'h0);
        run_job(2, 1, 1'b0, 0, res, ovf_o, lat);
        check("fp_sat_od", res, 32'h7F7F);
        check("fp_sat_ovf", {31'h0, ovf_o}, 32'h1);

        set4(16'hC040, 16'h4000, 16'h0, 16'h0, 16'h3F00, 16'h3F80, 16'h0, 16'h0);
        run_job(2, 2, 1'b0, 0, res, ovf_o, lat);
        check("fp_mixed", res, 32'h3F00);
        check("fp_ovf_clr", {31'h0, ovf_o}, 32'h0);

        // Abort an FP job mid-accumulation with async reset.
        @(negedge clk);
        start_v[2] = 1'b1;
        cfg_len    = 8'd4;
        @(negedge clk);
        start_v  = '0;
        in_valid = 1'b1;
        da = 16'h3F80;
        db = 16'h3F80;
        @(negedge clk);
        check("mid_busy", {31'h0, bz[2]}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", {20'h0, rdy, ov, bz, of}, 32'h0);
        check("mid_rst_od", {16'h0, od_fp}, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        set4(16'h3F80, 16'h0, 16'h0, 16'h0, 16'h3F80, 16'h0, 16'h0, 16'h0);
        run_job(2, 1, 1'b0, 0, res, ovf_o, lat);
        check("post_rst_fp", res, 32'h3F80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
